// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Control stage that sits in front of alu_regfile. One ALU instruction is
// accepted per valid/ready handshake and walked through three cycles:
//   IDLE : accept instruction (or let a host preload write through)
//   EXEC : drive read addresses / opcode / carry-in, capture ALU result
//   WB   : write the captured result to the destination register, pulse Done
//
// Optional build macro:
//   ALU_SEQ_CARRY_CHAIN_EN - when defined, an instruction with Instr_Carry=1
//     feeds the previous instruction's Carry_Flag into Carry_In (multi-word
//     add/sub). When undefined, Carry_In is the latched Instr_Carry bit.
//
// Ports
//   Clock, Reset_n          clock, async active-low reset
//   Instr_*                 instruction handshake and fields (Ready is output)
//   Host_Wr_*               host preload write, honoured only in IDLE
//   Read_Addr_1/2, Opcode,
//   Carry_In                ALU operand selection toward alu_regfile
//   Write_Addr/enable/data  regfile write port (host preload or writeback)
//   ALU_Out, Carry_Out      combinational ALU result from alu_regfile
//   Done                    single-cycle pulse during writeback
//   Result, Carry_Flag      last captured ALU result / carry, held
// -----------------------------------------------------------------------------
package alu_seq_pkg;
  localparam int REGFILE_ADDR_WIDTH = 4;
  localparam int REGFILE_WIDTH      = 8;
  localparam int ALU_OUTPUT_WIDTH   = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_PASS = 3'd5
  } aluop_t;
endpackage

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_WIDTH,
  parameter int DATA_W = REGFILE_WIDTH,
  parameter int ALU_W  = ALU_OUTPUT_WIDTH
) (
  input  logic              Clock,
  input  logic              Reset_n,
  // instruction handshake
  input  logic              Instr_Valid,
  output logic              Instr_Ready,
  input  aluop_t            Instr_Opcode,
  input  logic [ADDR_W-1:0] Instr_Src1,
  input  logic [ADDR_W-1:0] Instr_Src2,
  input  logic [ADDR_W-1:0] Instr_Dst,
  input  logic              Instr_Carry,
  // host preload
  input  logic              Host_Wr_Valid,
  input  logic [ADDR_W-1:0] Host_Wr_Addr,
  input  logic [DATA_W-1:0] Host_Wr_Data,
  // to alu_regfile
  output logic [ADDR_W-1:0] Read_Addr_1,
  output logic [ADDR_W-1:0] Read_Addr_2,
  output aluop_t            Opcode,
  output logic              Carry_In,
  output logic [ADDR_W-1:0] Write_Addr,
  output logic              Write_enable,
  output logic [DATA_W-1:0] Write_data,
  // from alu_regfile
  input  logic [ALU_W-1:0]  ALU_Out,
  input  logic              Carry_Out,
  // status
  output logic              Done,
  output logic [ALU_W-1:0]  Result,
  output logic              Carry_Flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    aluop_t            op;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] dst;
    logic              carry;
  } instr_t;

  state_t             state_q, state_d;
  instr_t             instr_q, instr_d;
  logic [ALU_W-1:0]   result_q, result_d;
  logic               cflag_q, cflag_d;
  logic               carry_sel;

  // Carry source presented to the ALU during EXEC.
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  assign carry_sel = instr_q.carry ? cflag_q : 1'b0;
`else
  assign carry_sel = instr_q.carry;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      result_q <= '0;
      cflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      cflag_q  <= cflag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    result_d     = result_q;
    cflag_d      = cflag_q;
    Instr_Ready  = 1'b0;
    Write_enable = 1'b0;
    Write_Addr   = '0;
    Write_data   = '0;
    Carry_In     = 1'b0;
    Done         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Reset_n gating keeps the combinational paths quiet while reset is
        // held, so every output reads zero during reset.
        if (Reset_n) begin
          Instr_Ready = !Host_Wr_Valid;
          if (Host_Wr_Valid) begin
            // host preload wins over a same-cycle instruction
            Write_enable = 1'b1;
            Write_Addr   = Host_Wr_Addr;
            Write_data   = Host_Wr_Data;
          end else if (Instr_Valid) begin
            instr_d.op    = Instr_Opcode;
            instr_d.src1  = Instr_Src1;
            instr_d.src2  = Instr_Src2;
            instr_d.dst   = Instr_Dst;
            instr_d.carry = Instr_Carry;
            state_d       = EXEC;
          end
        end
      end

      EXEC: begin
        Carry_In = carry_sel;
        result_d = ALU_Out;
        cflag_d  = Carry_Out;
        state_d  = WB;
      end

      WB: begin
        // Sources were read in EXEC, so Dst aliasing a source is harmless.
        Write_enable = 1'b1;
        Write_Addr   = instr_q.dst;
        Write_data   = DATA_W'(result_q);
        Done         = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Operand selection holds the last latched instruction outside EXEC.
  assign Read_Addr_1 = instr_q.src1;
  assign Read_Addr_2 = instr_q.src2;
  assign Opcode      = instr_q.op;
  assign Result      = result_q;
  assign Carry_Flag  = cflag_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
// Bench for alu_op_sequencer: small regfile+ALU stand-in, a timestamp-based
// behavioural model compared every half-cycle, and directed literal checks.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int OW = 8;

  logic          Clock = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Instr_Valid = 1'b0;
  logic          Instr_Ready;
  aluop_t        Instr_Opcode = OP_ADD;
  logic [AW-1:0] Instr_Src1 = '0, Instr_Src2 = '0, Instr_Dst = '0;
  logic          Instr_Carry = 1'b0;
  logic          Host_Wr_Valid = 1'b0;
  logic [AW-1:0] Host_Wr_Addr = '0;
  logic [DW-1:0] Host_Wr_Data = '0;
  logic [AW-1:0] Read_Addr_1, Read_Addr_2, Write_Addr;
  aluop_t        Opcode;
  logic          Carry_In, Write_enable, Carry_Out, Done, Carry_Flag;
  logic [DW-1:0] Write_data;
  logic [OW-1:0] ALU_Out, Result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  alu_op_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
    .Instr_Opcode(Instr_Opcode), .Instr_Src1(Instr_Src1), .Instr_Src2(Instr_Src2),
    .Instr_Dst(Instr_Dst), .Instr_Carry(Instr_Carry),
    .Host_Wr_Valid(Host_Wr_Valid), .Host_Wr_Addr(Host_Wr_Addr), .Host_Wr_Data(Host_Wr_Data),
    .Read_Addr_1(Read_Addr_1), .Read_Addr_2(Read_Addr_2), .Opcode(Opcode),
    .Carry_In(Carry_In), .Write_Addr(Write_Addr), .Write_enable(Write_enable),
    .Write_data(Write_data), .ALU_Out(ALU_Out), .Carry_Out(Carry_Out),
    .Done(Done), .Result(Result), .Carry_Flag(Carry_Flag)
  );

  // ALU semantics: {carry, result}; SUB carry is the borrow.
  function automatic logic [OW:0] alu_fn(aluop_t op, logic [DW-1:0] a, logic [DW-1:0] b, logic ci);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b} + {8'd0, ci};
      OP_SUB:  return {1'b0, a} - {1'b0, b} - {8'd0, ci};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_PASS: return {1'b0, a};
      default: return '0;
    endcase
  endfunction

  // alu_regfile stand-in
  logic [DW-1:0] rf_h [16] = '{default: '0};
  always @(posedge Clock) if (Write_enable) rf_h[Write_Addr] <= Write_data;
  assign {Carry_Out, ALU_Out} = alu_fn(Opcode, rf_h[Read_Addr_1], rf_h[Read_Addr_2], Carry_In);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: an instruction accepted in cycle c executes in c+1,
  // writes back in c+2 and the sequencer is free again from c+3.
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  int            acc = -100;
  aluop_t        m_op = OP_ADD;
  logic [AW-1:0] m_s1 = '0, m_s2 = '0, m_dst = '0;
  logic          m_c = 1'b0, m_cf = 1'b0;
  logic [OW-1:0] m_res = '0;
  logic [DW-1:0] mrf [16] = '{default: '0};

  always @(negedge Reset_n) begin
    acc = -100; m_op = OP_ADD; m_s1 = '0; m_s2 = '0; m_dst = '0;
    m_c = 1'b0; m_cf = 1'b0; m_res = '0;
  end

  always @(negedge Clock) begin
    if (!Reset_n) begin
      chk("rst.ready", 32'(Instr_Ready), 0);
      chk("rst.we",    32'(Write_enable), 0);
      chk("rst.waddr", 32'(Write_Addr), 0);
      chk("rst.wdata", 32'(Write_data), 0);
      chk("rst.done",  32'(Done), 0);
      chk("rst.ra1",   32'(Read_Addr_1), 0);
      chk("rst.ra2",   32'(Read_Addr_2), 0);
      chk("rst.op",    32'(Opcode), 0);
      chk("rst.cin",   32'(Carry_In), 0);
      chk("rst.res",   32'(Result), 0);
      chk("rst.cf",    32'(Carry_Flag), 0);
    end else begin
      bit rdy, ex, wb, hw;
      logic cin;
      rdy = (cyc >= acc + 3);
      ex  = (cyc == acc + 1);
      wb  = (cyc == acc + 2);
      hw  = rdy && Host_Wr_Valid;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      cin = ex ? (m_c ? m_cf : 1'b0) : 1'b0;
`else
      cin = ex ? m_c : 1'b0;
`endif
      chk("m.ready", 32'(Instr_Ready), 32'(rdy && !Host_Wr_Valid));
      chk("m.we",    32'(Write_enable), 32'(hw || wb));
      chk("m.waddr", 32'(Write_Addr), wb ? 32'(m_dst) : (hw ? 32'(Host_Wr_Addr) : 0));
      chk("m.wdata", 32'(Write_data), wb ? 32'(m_res) : (hw ? 32'(Host_Wr_Data) : 0));
      chk("m.done",  32'(Done), 32'(wb));
      chk("m.ra1",   32'(Read_Addr_1), 32'(m_s1));
      chk("m.ra2",   32'(Read_Addr_2), 32'(m_s2));
      chk("m.op",    32'(Opcode), 32'(m_op));
      chk("m.cin",   32'(Carry_In), 32'(cin));
      chk("m.res",   32'(Result), 32'(m_res));
      chk("m.cf",    32'(Carry_Flag), 32'(m_cf));
      // advance to the next cycle
      if (hw) mrf[Host_Wr_Addr] = Host_Wr_Data;
      else if (rdy && Instr_Valid) begin
        acc = cyc; m_op = Instr_Opcode; m_s1 = Instr_Src1; m_s2 = Instr_Src2;
        m_dst = Instr_Dst; m_c = Instr_Carry;
      end
      if (ex) {m_cf, m_res} = alu_fn(m_op, mrf[m_s1], mrf[m_s2], cin);
      if (wb) mrf[m_dst] = m_res;
      cyc++;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic host(input logic [AW-1:0] a, input logic [DW-1:0] d);
    Host_Wr_Valid = 1'b1; Host_Wr_Addr = a; Host_Wr_Data = d;
    tick();
    Host_Wr_Valid = 1'b0;
  endtask

  task automatic set_instr(input aluop_t op, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                           input logic [AW-1:0] d, input logic c);
    Instr_Opcode = op; Instr_Src1 = s1; Instr_Src2 = s2; Instr_Dst = d; Instr_Carry = c;
  endtask

  // Offer one instruction from IDLE; returns positioned in its WB cycle.
  task automatic run_to_wb(input aluop_t op, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                           input logic [AW-1:0] d, input logic c);
    set_instr(op, s1, s2, d, c);
    Instr_Valid = 1'b1;
    tick();
    Instr_Valid = 1'b0;
    tick();
  endtask

  initial begin
    // 1. reset
    tick(); tick();
    chk("t1.ready_in_rst", 32'(Instr_Ready), 0);
    chk("t1.res_in_rst", 32'(Result), 0);
    #2 Reset_n = 1'b1;
    tick();
    chk("t1.ready_after", 32'(Instr_Ready), 1);
    Host_Wr_Valid = 1'b1; Host_Wr_Addr = 4'd0; Host_Wr_Data = 8'h77;
    #1 chk("t1.host_we", 32'(Write_enable), 1);
    #2 Reset_n = 1'b0;
    #1 chk("t1.async_we", 32'(Write_enable), 0);
    chk("t1.async_wdata", 32'(Write_data), 0);
    #2 Reset_n = 1'b1; Host_Wr_Valid = 1'b0;
    tick();
    chk("t1.no_write", 32'(rf_h[0]), 0);

    // 2. single instruction
    host(4'd1, 8'h05);
    host(4'd2, 8'h03);
    run_to_wb(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0);
    chk("t2.done", 32'(Done), 1);
    chk("t2.waddr", 32'(Write_Addr), 3);
    chk("t2.wdata", 32'(Write_data), 32'h08);
    chk("t2.result", 32'(Result), 32'h08);
    tick();
    chk("t2.rf3", 32'(rf_h[3]), 32'h08);
    chk("t2.ready", 32'(Instr_Ready), 1);

    // 3. host write and instruction together
    set_instr(OP_ADD, 4'd4, 4'd1, 4'd5, 1'b0);
    Instr_Valid = 1'b1; Host_Wr_Valid = 1'b1; Host_Wr_Addr = 4'd4; Host_Wr_Data = 8'h10;
    #1 chk("t3.ready", 32'(Instr_Ready), 0);
    chk("t3.we", 32'(Write_enable), 1);
    tick();
    Host_Wr_Valid = 1'b0;
    #1 chk("t3.ready2", 32'(Instr_Ready), 1);
    chk("t3.rf4", 32'(rf_h[4]), 32'h10);
    tick();
    Instr_Valid = 1'b0;
    tick();
    chk("t3.done", 32'(Done), 1);
    chk("t3.wdata", 32'(Write_data), 32'h15);
    tick();

    // 4. back-to-back: Done pulses 3 cycles apart
    set_instr(OP_SUB, 4'd1, 4'd2, 4'd6, 1'b0);
    Instr_Valid = 1'b1;
    tick();
    set_instr(OP_XOR, 4'd3, 4'd4, 4'd7, 1'b0);
    chk("t4.done_t1", 32'(Done), 0);
    tick();
    chk("t4.done_t2", 32'(Done), 1);
    chk("t4.wdata_a", 32'(Write_data), 32'h02);
    tick();
    chk("t4.done_t3", 32'(Done), 0);
    chk("t4.ready_t3", 32'(Instr_Ready), 1);
    tick();
    Instr_Valid = 1'b0;
    chk("t4.done_t4", 32'(Done), 0);
    tick();
    chk("t4.done_t5", 32'(Done), 1);
    chk("t4.waddr_b", 32'(Write_Addr), 7);
    chk("t4.wdata_b", 32'(Write_data), 32'h18);
    tick();

    // 5. carry behaviour
    host(4'd8, 8'hFF);
    host(4'd9, 8'h01);
    run_to_wb(OP_ADD, 4'd8, 4'd9, 4'd12, 1'b0);
    chk("t5.res_ff", 32'(Result), 32'h00);
    chk("t5.cf_ff", 32'(Carry_Flag), 1);
    tick();
    run_to_wb(OP_ADD, 4'd10, 4'd11, 4'd13, 1'b1);
    chk("t5.res_chain", 32'(Result), 32'h01);
    chk("t5.cf_chain", 32'(Carry_Flag), 0);
    tick();
    run_to_wb(OP_ADD, 4'd10, 4'd11, 4'd14, 1'b1);
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    chk("t5.res_nochain", 32'(Result), 32'h00);
`else
    chk("t5.res_nochain", 32'(Result), 32'h01);
`endif
    tick();

    // 6. reset during EXEC abandons the instruction
    host(4'd15, 8'hAA);
    set_instr(OP_ADD, 4'd1, 4'd2, 4'd15, 1'b0);
    Instr_Valid = 1'b1;
    tick();
    Instr_Valid = 1'b0;
    #1 Reset_n = 1'b0;
    #1 chk("t6.we", 32'(Write_enable), 0);
    chk("t6.done", 32'(Done), 0);
    chk("t6.ra1", 32'(Read_Addr_1), 0);
    tick();
    #3 Reset_n = 1'b1;
    tick();
    chk("t6.rf15", 32'(rf_h[15]), 32'hAA);
    chk("t6.ready", 32'(Instr_Ready), 1);

    // 7. destination aliases a source
    run_to_wb(OP_ADD, 4'd1, 4'd1, 4'd1, 1'b0);
    chk("t7.wdata", 32'(Write_data), 32'h0A);
    tick();
    chk("t7.rf1", 32'(rf_h[1]), 32'h0A);
    run_to_wb(OP_AND, 4'd5, 4'd7, 4'd2, 1'b0);
    chk("t7.and", 32'(Write_data), 32'h10);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
